// File: rtl/register_scoreboard_pkg.sv
// Shared constants for the register scoreboard: counter/index widths, per-file register counts,
// named register indices and a bit-count helper used by the pending counters.
package register_scoreboard_pkg;

   localparam int CNT_W_DEF    = 2;
   localparam int IDX_W_DEF    = 3;

   localparam int GPR_NUM_REGS = 8;
   localparam int SEG_NUM_REGS = 6;
   localparam int MMX_NUM_REGS = 8;

   localparam int REG_ESP      = 4;
   localparam int REG_ESI      = 6;
   localparam int REG_EDI      = 7;

   function automatic int unsigned count_ones(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) n += 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode-to-address-generation handshake plus writeback release ports seen by the scoreboard.
// The decode side drives master; the scoreboard takes slave.
interface register_scoreboard_if
   import register_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = GPR_NUM_REGS,
   parameter int WB_PORTS = 1,
   parameter int IDX_W    = IDX_W_DEF
);
   logic                      d_valid;
   logic                      d_ready;
   logic [NUM_REGS-1:0]       d_src_mask;
   logic [NUM_REGS-1:0]       d_dst_mask;
   logic                      r_valid;
   logic                      r_ready;
   logic [WB_PORTS-1:0]       wb_en;
   logic [WB_PORTS*IDX_W-1:0] wb_reg;

   modport master (
      output d_valid, d_src_mask, d_dst_mask, r_ready, wb_en, wb_reg,
      input  d_ready, r_valid
   );

   modport slave (
      input  d_valid, d_src_mask, d_dst_mask, r_ready, wb_en, wb_reg,
      output d_ready, r_valid
   );
endinterface

// File: rtl/register_scoreboard_counter.sv
// One register's pending-write counter: registered, saturating at 2^CNT_W-1, clamps to 0 on underflow.
// Flush zeroes it at the next edge and discards same-cycle writebacks (no underflow pulse).
module scoreboard_counter
   import register_scoreboard_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WB_PORTS = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                inc,
   input  logic [WB_PORTS-1:0] dec_hit,
   output logic [CNT_W-1:0]    count,
   output logic                nonzero,
   output logic                at_max,
   output logic                underflow
);
   localparam int SW = CNT_W + WB_PORTS + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SW-1:0]    sum;
   logic [SW-1:0]    dec;
   logic [SW-1:0]    diff;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      sum       = SW'(count) + SW'(inc);
      dec       = SW'(count_ones(32'(dec_hit)));
      diff      = sum - dec;
      underflow = 1'b0;
      cnt_nxt   = count;
      if (flush) begin
         cnt_nxt = '0;
      end else if (dec > sum) begin
         cnt_nxt   = '0;
         underflow = 1'b1;
      end else if (diff > SW'(CNT_MAX)) begin
         cnt_nxt = CNT_MAX;
      end else begin
         cnt_nxt = diff[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count <= '0;
      else       count <= cnt_nxt;
   end

   assign nonzero = |count;
   assign at_max  = (count == CNT_MAX);
endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard gating decode->AGU issue on pending writes; handshake is combinational, zero latency.
// REGISTER_SCOREBOARD_WB_BYPASS_EN lets a final writeback release a dependent in the same cycle.
module register_scoreboard
   import register_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = GPR_NUM_REGS,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WB_PORTS = 1,
   parameter int IDX_W    = IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   register_scoreboard_if.slave bus,
   output logic [NUM_REGS-1:0]  busy_mask,
   output logic                 stall,
   output logic                 underflow_err
);
   logic [NUM_REGS-1:0] busy_eff;
   logic [NUM_REGS-1:0] at_max;
   logic [NUM_REGS-1:0] uf;
   logic [NUM_REGS-1:0] inc;
   logic                hazard;
   logic                sat;
   logic                accept;

   assign accept = bus.d_valid & bus.d_ready;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WB_PORTS-1:0] hit;
      logic [CNT_W-1:0]    count;

      // Indices >= NUM_REGS never match any counter, so they are silently dropped.
      always_comb begin
         hit = '0;
         for (int p = 0; p < WB_PORTS; p++)
            hit[p] = bus.wb_en[p] && (bus.wb_reg[p*IDX_W +: IDX_W] == IDX_W'(gi));
      end

      assign inc[gi] = accept & bus.d_dst_mask[gi];

      scoreboard_counter #(
         .CNT_W    (CNT_W),
         .WB_PORTS (WB_PORTS)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .inc       (inc[gi]),
         .dec_hit   (hit),
         .count     (count),
         .nonzero   (busy_mask[gi]),
         .at_max    (at_max[gi]),
         .underflow (uf[gi])
      );

`ifdef REGISTER_SCOREBOARD_WB_BYPASS_EN
      assign busy_eff[gi] = busy_mask[gi] & ~((count == CNT_W'(1)) & (|hit));
`else
      // Registered view only: keeps wb_* off the combinational path to d_ready/r_valid.
      assign busy_eff[gi] = (count != '0);
`endif
   end

   assign hazard      = |(bus.d_src_mask & busy_eff);
   assign sat         = |(bus.d_dst_mask & at_max);
   assign stall       = hazard | sat | flush;
   assign bus.r_valid = bus.d_valid & ~stall;
   assign bus.d_ready = bus.r_ready & ~stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    underflow_err <= 1'b0;
      else if (|uf) underflow_err <= 1'b1;
   end
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard (8 regs, CNT_W=2, two writeback ports) with a reference
// model; post-edge state expectations queue up at drive time and are popped once the edge has passed.
module tb_register_scoreboard;
   localparam int NR = 8;

   logic          clk;
   logic          reset;
   logic          flush;
   logic [NR-1:0] busy_mask;
   logic          stall;
   logic          underflow_err;

   register_scoreboard_if #(.NUM_REGS(NR), .WB_PORTS(2), .IDX_W(3)) bus ();

   register_scoreboard #(
      .NUM_REGS (NR),
      .CNT_W    (2),
      .WB_PORTS (2),
      .IDX_W    (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .bus           (bus),
      .busy_mask     (busy_mask),
      .stall         (stall),
      .underflow_err (underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NR-1:0] busy;
      logic          err;
   } st_t;

   st_t exp_q[$];
   int  mcnt[NR];
   logic merr;
   int  n_tests;
   int  n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mcnt[i] = 0;
      merr = 1'b0;
   endtask

   // Drive one cycle from the negedge, check the combinational handshake, then the registered state.
   task automatic step(input string tag, input logic v, input logic [NR-1:0] src,
                       input logic [NR-1:0] dst, input logic rr, input logic [1:0] we,
                       input logic [2:0] w0, input logic [2:0] w1, input logic fl);
      logic [NR-1:0] beff;
      logic          sat;
      logic          stl;
      logic          acc;
      int            dec;
      int            incv;
      st_t           e;
      bus.d_valid    = v;
      bus.d_src_mask = src;
      bus.d_dst_mask = dst;
      bus.r_ready    = rr;
      bus.wb_en      = we;
      bus.wb_reg     = {w1, w0};
      flush          = fl;
      beff = '0;
      sat  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         dec = int'(we[0] && (w0 == 3'(i))) + int'(we[1] && (w1 == 3'(i)));
         beff[i] = (mcnt[i] != 0);
`ifdef REGISTER_SCOREBOARD_WB_BYPASS_EN
         if (mcnt[i] == 1 && dec > 0) beff[i] = 1'b0;
`endif
         if (dst[i] && mcnt[i] == 3) sat = 1'b1;
      end
      stl = (|(src & beff)) | sat | fl;
      acc = v & rr & ~stl;
      #1;
      check({tag, ".stall"},   32'(stall),       32'(stl));
      check({tag, ".r_valid"}, 32'(bus.r_valid), 32'(v & ~stl));
      check({tag, ".d_ready"}, 32'(bus.d_ready), 32'(rr & ~stl));
      for (int i = 0; i < NR; i++) begin
         dec  = int'(we[0] && (w0 == 3'(i))) + int'(we[1] && (w1 == 3'(i)));
         incv = int'(acc && dst[i]);
         if (fl) mcnt[i] = 0;
         else if (dec > mcnt[i] + incv) begin
            mcnt[i] = 0;
            merr    = 1'b1;
         end else mcnt[i] = mcnt[i] + incv - dec;
      end
      for (int i = 0; i < NR; i++) e.busy[i] = (mcnt[i] != 0);
      e.err = merr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".busy_mask"},     32'(busy_mask),     32'(e.busy));
      check({tag, ".underflow_err"}, 32'(underflow_err), 32'(e.err));
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      reset          = 1'b1;
      flush          = 1'b0;
      bus.d_valid    = 1'b0;
      bus.d_src_mask = '0;
      bus.d_dst_mask = '0;
      bus.r_ready    = 1'b1;
      bus.wb_en      = '0;
      bus.wb_reg     = '0;
      #12;
      check("rst.busy_mask", 32'(busy_mask), 32'h0);
      check("rst.underflow", 32'(underflow_err), 32'h0);
      check("rst.stall",     32'(stall), 32'h0);
      bus.d_valid = 1'b1;
      #1;
      check("rst.r_valid_follows", 32'(bus.r_valid), 32'h1);
      @(negedge clk);
      reset = 1'b0;

      // Basic issue, then a RAW hazard released by writeback on port 0.
      step("issue1",   1, 8'h01, 8'h02, 1, 2'b00, 3'd0, 3'd0, 0);
      check("issue1.busy_const", 32'(busy_mask), 32'h02);
      step("raw_stall", 1, 8'h02, 8'h00, 1, 2'b00, 3'd0, 3'd0, 0);
      step("raw_wb",    1, 8'h02, 8'h00, 1, 2'b01, 3'd1, 3'd0, 0);
      step("raw_after", 1, 8'h02, 8'h00, 1, 2'b00, 3'd0, 3'd0, 0);

      // Saturation on reg 3, release via port 1.
      step("sat_a", 1, 8'h00, 8'h08, 1, 2'b00, 3'd0, 3'd0, 0);
      step("sat_b", 1, 8'h00, 8'h08, 1, 2'b00, 3'd0, 3'd0, 0);
      step("sat_c", 1, 8'h00, 8'h08, 1, 2'b00, 3'd0, 3'd0, 0);
      step("sat_full", 1, 8'h00, 8'h08, 1, 2'b00, 3'd0, 3'd0, 0);
      step("sat_wb",   1, 8'h00, 8'h08, 1, 2'b10, 3'd0, 3'd3, 0);
      step("sat_resume", 1, 8'h00, 8'h08, 1, 2'b00, 3'd0, 3'd0, 0);

      // Both ports release reg 5 (count 2) in one cycle.
      step("dual_a",  1, 8'h00, 8'h20, 1, 2'b00, 3'd0, 3'd0, 0);
      step("dual_b",  1, 8'h00, 8'h20, 1, 2'b00, 3'd0, 3'd0, 0);
      step("dual_wb", 0, 8'h00, 8'h00, 1, 2'b11, 3'd5, 3'd5, 0);
      check("dual_wb.busy5_const", 32'(busy_mask[5]), 32'h0);

      // Underflow on idle reg 6, sticky through later activity and flush.
      step("uflow", 0, 8'h00, 8'h00, 1, 2'b01, 3'd6, 3'd0, 0);
      check("uflow.err_const", 32'(underflow_err), 32'h1);

      // Downstream not ready: no accept, no counter change.
      step("no_rdy", 1, 8'h00, 8'h01, 0, 2'b00, 3'd0, 3'd0, 0);

      // Flush overrides a simultaneous accept attempt.
      step("fl_a",  1, 8'h00, 8'h03, 1, 2'b00, 3'd0, 3'd0, 0);
      step("fl_b",  1, 8'h00, 8'h02, 1, 2'b00, 3'd0, 3'd0, 0);
      step("flush", 1, 8'h00, 8'h04, 1, 2'b01, 3'd0, 3'd0, 1);
      check("flush.busy_const", 32'(busy_mask), 32'h0);
      check("flush.err_kept",   32'(underflow_err), 32'h1);

      // Same idle register as source and destination.
      step("selfdep", 1, 8'h10, 8'h10, 1, 2'b00, 3'd0, 3'd0, 0);

      // Asynchronous reset between edges.
      #2;
      reset = 1'b1;
      #1;
      check("async_rst.busy", 32'(busy_mask), 32'h0);
      check("async_rst.err",  32'(underflow_err), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step("post_rst", 1, 8'h10, 8'h00, 1, 2'b00, 3'd0, 3'd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
